// File: rtl/spike_line_scheduler_if.sv
// Bus bundle for spike_line_scheduler.
//   master : environment side (line producer, window consumer, config source)
//   slave  : scheduler side
// Signals:
//   code_valid/conv_img_size        image start + padded size
//   i_line_valid/i_line_data        incoming packed spike line
//   o_line_ready                    scheduler can take a line
//   o_bram_wr_en/_slot/_data        temp BRAM write port
//   o_win_valid/_base_slot/o_win_idx, i_win_done   3-line window handshake
//   o_img_done/o_overflow/o_cfg_err status
interface spike_line_scheduler_if #(
  parameter int LINE_W = 128,
  parameter int SLOTS  = 4
);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic              code_valid;
  logic [15:0]       conv_img_size;
  logic              i_line_valid;
  logic [LINE_W-1:0] i_line_data;
  logic              o_line_ready;
  logic              o_bram_wr_en;
  logic [SLOT_W-1:0] o_bram_wr_slot;
  logic [LINE_W-1:0] o_bram_wr_data;
  logic              o_win_valid;
  logic [SLOT_W-1:0] o_win_base_slot;
  logic              i_win_done;
  logic [15:0]       o_win_idx;
  logic              o_img_done;
  logic              o_overflow;
  logic              o_cfg_err;

  modport master (
    output code_valid, conv_img_size, i_line_valid, i_line_data, i_win_done,
    input  o_line_ready, o_bram_wr_en, o_bram_wr_slot, o_bram_wr_data,
           o_win_valid, o_win_base_slot, o_win_idx, o_img_done, o_overflow,
           o_cfg_err
  );

  modport slave (
    input  code_valid, conv_img_size, i_line_valid, i_line_data, i_win_done,
    output o_line_ready, o_bram_wr_en, o_bram_wr_slot, o_bram_wr_data,
           o_win_valid, o_win_base_slot, o_win_idx, o_img_done, o_overflow,
           o_cfg_err
  );
endinterface

// File: rtl/spike_line_scheduler.sv
// spike_line_scheduler: buffers packed spike lines in a SLOTS-deep BRAM ring
// and offers sliding 3-line windows (oldest slot = o_win_base_slot) to a
// convolution consumer, one window per output row.
// Ports:
//   s_clk  rising-edge clock
//   s_rst  synchronous active-high reset
//   bus    spike_line_scheduler_if.slave (config, line input, BRAM write,
//          window handshake, status)
// An image of N = conv_img_size-2 lines yields N-2 windows. Each released
// window frees its oldest slot, so the ring holds at most SLOTS lines.
module spike_line_scheduler #(
  parameter int LINE_W = 128,
  parameter int SLOTS  = 4,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input logic                   s_clk,
  input logic                   s_rst,
  spike_line_scheduler_if.slave bus
);

  localparam logic [SLOT_W:0]   OCC_MAX  = (SLOT_W+1)'(SLOTS);
  localparam logic [SLOT_W:0]   OCC_WIN  = (SLOT_W+1)'(3);
  localparam logic [SLOT_W-1:0] PTR_LAST = SLOT_W'(SLOTS-1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t state, state_nxt;

  logic [15:0]       n_lines;
  logic [15:0]       lines_written;
  logic [15:0]       win_cnt;
  logic [SLOT_W:0]   occ;
  logic [SLOT_W-1:0] wr_ptr, rd_ptr;

  logic              wr_en;
  logic [SLOT_W-1:0] wr_slot;
  logic [LINE_W-1:0] wr_data;
  logic              win_valid;
  logic [SLOT_W-1:0] win_base;
  logic [15:0]       win_idx;
  logic              img_done, overflow, cfg_err;

  logic line_ready, accept, drop, release_w, last_win, offer;
  logic cfg_ok, cfg_bad;

  function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + SLOT_W'(1);
  endfunction

  // ---- FSM: state register ----
  always_ff @(posedge s_clk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- FSM: next state and per-cycle strobes ----
  always_comb begin
    state_nxt  = state;
    cfg_ok     = 1'b0;
    cfg_bad    = 1'b0;
    line_ready = ((state == FILL) || (state == RUN)) &&
                 (occ < OCC_MAX) && (lines_written < n_lines);
    accept     = bus.i_line_valid && line_ready;
    drop       = bus.i_line_valid && !line_ready;
    // a done pulse only counts against an outstanding window
    release_w  = bus.i_win_done && win_valid;
    last_win   = release_w && (win_cnt == n_lines - 16'd3);
    // a window is offered one cycle after occ>=3 with none outstanding;
    // the cycle of a release always has win_valid high, which yields the
    // mandatory one-cycle gap between consecutive windows
    offer      = ((state == FILL) || (state == RUN)) &&
                 !win_valid && (occ >= OCC_WIN);
    unique case (state)
      IDLE: begin
        if (bus.code_valid) begin
          if (bus.conv_img_size >= 16'd5) begin
            cfg_ok    = 1'b1;
            state_nxt = FILL;
          end else begin
            cfg_bad = 1'b1;
          end
        end
      end
      FILL:  if (occ >= OCC_WIN) state_nxt = RUN;
      RUN:   if (last_win) state_nxt = FLUSH;
      FLUSH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- datapath: ring pointers, counters, registered outputs ----
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      n_lines       <= '0;
      lines_written <= '0;
      win_cnt       <= '0;
      occ           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_en         <= 1'b0;
      wr_slot       <= '0;
      wr_data       <= '0;
      win_valid     <= 1'b0;
      win_base      <= '0;
      win_idx       <= '0;
      img_done      <= 1'b0;
      overflow      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      wr_en    <= accept;
      img_done <= last_win;
      cfg_err  <= cfg_bad;

      if (accept) begin
        wr_slot       <= wr_ptr;
        wr_data       <= bus.i_line_data;
        wr_ptr        <= ptr_inc(wr_ptr);
        lines_written <= lines_written + 16'd1;
      end

      // simultaneous write and release cancel out
      unique case ({accept, release_w})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase

      if (release_w) begin
        win_valid <= 1'b0;
        rd_ptr    <= ptr_inc(rd_ptr);
        win_cnt   <= win_cnt + 16'd1;
      end else if (offer) begin
        win_valid <= 1'b1;
        win_base  <= rd_ptr;
        win_idx   <= win_cnt;
      end

      // end of image: leftover lines are discarded
      if (last_win) begin
        occ    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end

      if (cfg_ok) begin
        n_lines       <= bus.conv_img_size - 16'd2;
        lines_written <= '0;
        win_cnt       <= '0;
        occ           <= '0;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        overflow      <= 1'b0;
      end

      // a dropped line wins over the clear on the same edge
      if (drop) overflow <= 1'b1;
    end
  end

  assign bus.o_line_ready    = line_ready;
  assign bus.o_bram_wr_en    = wr_en;
  assign bus.o_bram_wr_slot  = wr_slot;
  assign bus.o_bram_wr_data  = wr_data;
  assign bus.o_win_valid     = win_valid;
  assign bus.o_win_base_slot = win_base;
  assign bus.o_win_idx       = win_idx;
  assign bus.o_img_done      = img_done;
  assign bus.o_overflow      = overflow;
  assign bus.o_cfg_err       = cfg_err;

endmodule
